// File: rtl/ldst_drain_sched.sv
// ldst_drain_sched: arbitrates load/store buffer heads onto the cache array and sequences single-outstanding block refills.
// Optional counters are enabled by defining LDST_SCHED_PERF_EN.
module ldst_drain_sched #(
    parameter int ADDR_BITS      = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int BLOCK_ID_START = 5,
    parameter int R_WIDTH        = 6,
    parameter int MICROOP        = 5,
    parameter int ROB_TICKET     = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ld_valid,
    input  logic                  ld_head_isfetched,
    input  logic [ADDR_BITS-1:0]  ld_head_address,
    input  logic [MICROOP-1:0]    ld_head_microop,
    input  logic [R_WIDTH-1:0]    ld_head_dest,
    input  logic [ROB_TICKET-1:0] ld_head_ticket,
    output logic                  ld_pop,
    input  logic                  st_valid,
    input  logic                  st_ready,
    input  logic                  st_head_isfetched,
    input  logic [ADDR_BITS-1:0]  st_head_address,
    input  logic [DATA_WIDTH-1:0] st_head_data,
    input  logic [MICROOP-1:0]    st_head_microop,
    output logic                  st_pop,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_BITS-1:0]  mem_req_address,
    input  logic                  mem_resp_valid,
    output logic                  update_valid,
    output logic [ADDR_BITS-1:0]  update_address,
    output logic                  cache_wr_en,
    output logic [ADDR_BITS-1:0]  cache_wr_address,
    output logic [DATA_WIDTH-1:0] cache_wr_data,
    output logic [MICROOP-1:0]    cache_wr_microop,
    output logic                  ld_srv_valid,
    output logic [ADDR_BITS-1:0]  ld_srv_address,
    output logic [R_WIDTH-1:0]    ld_srv_dest,
    output logic [ROB_TICKET-1:0] ld_srv_ticket,
    output logic [MICROOP-1:0]    ld_srv_microop,
`ifdef LDST_SCHED_PERF_EN
    output logic [31:0]           perf_refills,
    output logic [31:0]           perf_ld_blocked,
    output logic [31:0]           perf_st_full,
`endif
    output logic                  busy
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, FILL} state_t;

    state_t                r_state, w_next;
    logic                  r_last_st;
    logic                  r_after_fill;
    logic [ADDR_BITS-1:0]  r_req_addr;
    logic                  r_wr_en;
    logic [ADDR_BITS-1:0]  r_wr_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic [MICROOP-1:0]    r_wr_uop;
    logic                  r_srv_valid;
    logic [ADDR_BITS-1:0]  r_srv_addr;
    logic [R_WIDTH-1:0]    r_srv_dest;
    logic [ROB_TICKET-1:0] r_srv_ticket;
    logic [MICROOP-1:0]    r_srv_uop;

    logic                  w_fill;
    logic                  w_same_word;
    logic                  w_ld_ok;
    logic                  w_st_ok;
    logic                  w_gnt_ld;
    logic                  w_gnt_st;
    logic                  w_ld_miss;
    logic                  w_st_miss;
    logic                  w_pick_st;
    logic [ADDR_BITS-1:0]  w_miss_addr;
    logic [ADDR_BITS-1:0]  w_aligned;
    logic                  w_start;

    assign w_fill      = r_state == FILL;
    assign w_same_word = st_head_address[ADDR_BITS-1:2] == ld_head_address[ADDR_BITS-1:2];
    assign w_ld_ok     = ld_valid & ld_head_isfetched & ~(st_valid & w_same_word);
    assign w_st_ok     = st_valid & st_head_isfetched;
    // A full store buffer forces the store through; otherwise a tie goes to whoever did not win last.
    assign w_gnt_st    = rst_n & ~w_fill & w_st_ok & (~st_ready | ~w_ld_ok | ~r_last_st);
    assign w_gnt_ld    = rst_n & ~w_fill & w_ld_ok & ~w_gnt_st;
    assign ld_pop      = w_gnt_ld;
    assign st_pop      = w_gnt_st;

    assign w_ld_miss   = ld_valid & ~ld_head_isfetched;
    assign w_st_miss   = st_valid & ~st_head_isfetched;
    assign w_pick_st   = w_st_miss & (~st_ready | ~w_ld_miss);
    assign w_miss_addr = w_pick_st ? st_head_address : ld_head_address;
    assign w_aligned   = {w_miss_addr[ADDR_BITS-1:BLOCK_ID_START], {BLOCK_ID_START{1'b0}}};
    // Heads only observe isfetched the cycle after FILL, so hold off a new request until then.
    assign w_start     = (w_ld_miss | w_st_miss) & ~r_after_fill;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: w_next = w_start ? REQ : IDLE;
            REQ:  w_next = mem_req_ready ? WAIT : REQ;
            WAIT: w_next = mem_resp_valid ? FILL : WAIT;
            FILL: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_last_st    <= 1'b1;
            r_after_fill <= 1'b0;
            r_req_addr   <= '0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_wr_uop     <= '0;
            r_srv_valid  <= 1'b0;
            r_srv_addr   <= '0;
            r_srv_dest   <= '0;
            r_srv_ticket <= '0;
            r_srv_uop    <= '0;
        end else begin
            r_state      <= w_next;
            r_after_fill <= w_fill;
            r_wr_en      <= w_gnt_st;
            r_srv_valid  <= w_gnt_ld;
            if (r_state == IDLE && w_start)
                r_req_addr <= w_aligned;
            if (w_gnt_ld | w_gnt_st)
                r_last_st <= w_gnt_st;
            if (w_gnt_st) begin
                r_wr_addr <= st_head_address;
                r_wr_data <= st_head_data;
                r_wr_uop  <= st_head_microop;
            end
            if (w_gnt_ld) begin
                r_srv_addr   <= ld_head_address;
                r_srv_dest   <= ld_head_dest;
                r_srv_ticket <= ld_head_ticket;
                r_srv_uop    <= ld_head_microop;
            end
        end
    end

    assign mem_req_valid    = r_state == REQ;
    assign mem_req_address  = r_req_addr;
    assign update_valid     = w_fill;
    assign update_address   = r_req_addr;
    assign busy             = r_state != IDLE;
    assign cache_wr_en      = r_wr_en;
    assign cache_wr_address = r_wr_addr;
    assign cache_wr_data    = r_wr_data;
    assign cache_wr_microop = r_wr_uop;
    assign ld_srv_valid     = r_srv_valid;
    assign ld_srv_address   = r_srv_addr;
    assign ld_srv_dest      = r_srv_dest;
    assign ld_srv_ticket    = r_srv_ticket;
    assign ld_srv_microop   = r_srv_uop;

`ifdef LDST_SCHED_PERF_EN
    logic w_ld_blocked;

    assign w_ld_blocked = ld_valid & ld_head_isfetched & (~w_ld_ok | w_gnt_st);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_refills    <= '0;
            perf_ld_blocked <= '0;
            perf_st_full    <= '0;
        end else begin
            perf_refills    <= perf_refills + {31'd0, (r_state == REQ) & mem_req_ready & ~&perf_refills};
            perf_ld_blocked <= perf_ld_blocked + {31'd0, w_ld_blocked & ~&perf_ld_blocked};
            perf_st_full    <= perf_st_full + {31'd0, ~st_ready & ~&perf_st_full};
        end
    end
`endif
endmodule

// File: tb/tb_ldst_drain_sched.sv
// tb_ldst_drain_sched: directed and random stimulus checked against a transaction-level model of the scheduler.
module tb_ldst_drain_sched;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        ld_valid, ld_head_isfetched;
    logic [31:0] ld_head_address;
    logic [4:0]  ld_head_microop;
    logic [5:0]  ld_head_dest;
    logic [2:0]  ld_head_ticket;
    logic        ld_pop;
    logic        st_valid, st_ready, st_head_isfetched;
    logic [31:0] st_head_address, st_head_data;
    logic [4:0]  st_head_microop;
    logic        st_pop;
    logic        mem_req_valid, mem_req_ready, mem_resp_valid;
    logic [31:0] mem_req_address;
    logic        update_valid;
    logic [31:0] update_address;
    logic        cache_wr_en;
    logic [31:0] cache_wr_address, cache_wr_data;
    logic [4:0]  cache_wr_microop;
    logic        ld_srv_valid;
    logic [31:0] ld_srv_address;
    logic [5:0]  ld_srv_dest;
    logic [2:0]  ld_srv_ticket;
    logic [4:0]  ld_srv_microop;
    logic        busy;
`ifdef LDST_SCHED_PERF_EN
    logic [31:0] perf_refills, perf_ld_blocked, perf_st_full;
    int          m_refills, m_blocked, m_full;
`endif

    int total = 0;
    int bad = 0;

    ldst_drain_sched dut (
        .clk(clk), .rst_n(rst_n),
        .ld_valid(ld_valid), .ld_head_isfetched(ld_head_isfetched), .ld_head_address(ld_head_address),
        .ld_head_microop(ld_head_microop), .ld_head_dest(ld_head_dest), .ld_head_ticket(ld_head_ticket),
        .ld_pop(ld_pop),
        .st_valid(st_valid), .st_ready(st_ready), .st_head_isfetched(st_head_isfetched),
        .st_head_address(st_head_address), .st_head_data(st_head_data), .st_head_microop(st_head_microop),
        .st_pop(st_pop),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_address(mem_req_address),
        .mem_resp_valid(mem_resp_valid),
        .update_valid(update_valid), .update_address(update_address),
        .cache_wr_en(cache_wr_en), .cache_wr_address(cache_wr_address), .cache_wr_data(cache_wr_data),
        .cache_wr_microop(cache_wr_microop),
        .ld_srv_valid(ld_srv_valid), .ld_srv_address(ld_srv_address), .ld_srv_dest(ld_srv_dest),
        .ld_srv_ticket(ld_srv_ticket), .ld_srv_microop(ld_srv_microop),
`ifdef LDST_SCHED_PERF_EN
        .perf_refills(perf_refills), .perf_ld_blocked(perf_ld_blocked), .perf_st_full(perf_st_full),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Refill progress as a transaction: none, asked (not yet accepted), in flight, data landing.
    int          m_stage;
    bit          m_last_was_st;
    bit          m_just_filled;
    logic [31:0] m_blk;
    logic        e_wr_en, e_srv_valid;
    logic [31:0] e_wr_addr, e_wr_data, e_srv_addr;
    logic [4:0]  e_wr_uop, e_srv_uop;
    logic [5:0]  e_srv_dest;
    logic [2:0]  e_srv_ticket;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_stage = 0; m_last_was_st = 1'b1; m_just_filled = 1'b0; m_blk = '0;
        e_wr_en = 0; e_wr_addr = 0; e_wr_data = 0; e_wr_uop = 0;
        e_srv_valid = 0; e_srv_addr = 0; e_srv_dest = 0; e_srv_ticket = 0; e_srv_uop = 0;
`ifdef LDST_SCHED_PERF_EN
        m_refills = 0; m_blocked = 0; m_full = 0;
`endif
    endtask

    task automatic set_ld(input bit v, input bit f, input logic [31:0] a, input logic [5:0] d, input logic [2:0] t, input logic [4:0] u);
        ld_valid = v; ld_head_isfetched = f; ld_head_address = a; ld_head_dest = d; ld_head_ticket = t; ld_head_microop = u;
    endtask

    task automatic set_st(input bit v, input bit r, input bit f, input logic [31:0] a, input logic [31:0] dat, input logic [4:0] u);
        st_valid = v; st_ready = r; st_head_isfetched = f; st_head_address = a; st_head_data = dat; st_head_microop = u;
    endtask

    // Called just after a falling edge with inputs applied; checks this cycle and the registered results.
    task automatic step();
        bit ld_can, st_can, g_ld, g_st, ld_miss, st_miss, want_st;
        ld_can = ld_valid && ld_head_isfetched && !(st_valid && ld_head_address[31:2] == st_head_address[31:2]);
        st_can = st_valid && st_head_isfetched;
        g_ld = 0; g_st = 0;
        if (m_stage != 3) begin
            if (!st_ready && st_can) g_st = 1;
            else if (ld_can && st_can) begin g_st = !m_last_was_st; g_ld = m_last_was_st; end
            else begin g_ld = ld_can; g_st = st_can; end
        end
        #1;
        chk("ld_pop", ld_pop, g_ld);
        chk("st_pop", st_pop, g_st);
        chk("mem_req_valid", mem_req_valid, m_stage == 1);
        chk("mem_req_address", mem_req_address, m_blk);
        chk("update_valid", update_valid, m_stage == 3);
        chk("update_address", update_address, m_blk);
        chk("busy", busy, m_stage != 0);
`ifdef LDST_SCHED_PERF_EN
        if (m_stage == 1 && mem_req_ready) m_refills++;
        if (ld_valid && ld_head_isfetched && !g_ld && (!ld_can || g_st)) m_blocked++;
        if (!st_ready) m_full++;
`endif
        if (g_ld || g_st) m_last_was_st = g_st;
        e_wr_en = g_st; e_srv_valid = g_ld;
        if (g_st) begin e_wr_addr = st_head_address; e_wr_data = st_head_data; e_wr_uop = st_head_microop; end
        if (g_ld) begin
            e_srv_addr = ld_head_address; e_srv_dest = ld_head_dest;
            e_srv_ticket = ld_head_ticket; e_srv_uop = ld_head_microop;
        end
        ld_miss = ld_valid && !ld_head_isfetched;
        st_miss = st_valid && !st_head_isfetched;
        want_st = st_miss && (!st_ready || !ld_miss);
        case (m_stage)
            0: if ((ld_miss || st_miss) && !m_just_filled) begin
                   m_stage = 1;
                   m_blk = (want_st ? st_head_address : ld_head_address) & ~32'h1F;
               end
            1: if (mem_req_ready) m_stage = 2;
            2: if (mem_resp_valid) m_stage = 3;
            default: m_stage = 0;
        endcase
        m_just_filled = (m_stage == 0) && update_valid;
        @(posedge clk);
        #1;
        chk("cache_wr_en", cache_wr_en, e_wr_en);
        chk("cache_wr_address", cache_wr_address, e_wr_addr);
        chk("cache_wr_data", cache_wr_data, e_wr_data);
        chk("cache_wr_microop", cache_wr_microop, e_wr_uop);
        chk("ld_srv_valid", ld_srv_valid, e_srv_valid);
        chk("ld_srv_address", ld_srv_address, e_srv_addr);
        chk("ld_srv_dest", ld_srv_dest, e_srv_dest);
        chk("ld_srv_ticket", ld_srv_ticket, e_srv_ticket);
        chk("ld_srv_microop", ld_srv_microop, e_srv_uop);
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pops"}, {ld_pop, st_pop}, 2'b00);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_req"}, {mem_req_valid, mem_req_address}, 33'd0);
        chk({tag, "_upd"}, {update_valid, update_address}, 33'd0);
        chk({tag, "_wr"}, {cache_wr_en, cache_wr_address, cache_wr_microop}, 38'd0);
        chk({tag, "_wrdata"}, cache_wr_data, 32'd0);
        chk({tag, "_srv"}, {ld_srv_valid, ld_srv_address, ld_srv_dest, ld_srv_ticket, ld_srv_microop}, 47'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        mem_req_ready = 0; mem_resp_valid = 0;
        set_ld(1, 1, 32'h40, 6'h3, 3'h1, 5'h2);
        set_st(1, 1, 1, 32'h80, 32'h1234, 5'h4);
        model_reset();
        repeat (2) @(negedge clk);
        #1 chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Both heads fetched, different words: first tie goes to the load, then alternates.
        set_ld(1, 1, 32'h40, 6'h3, 3'h1, 5'h2);
        set_st(1, 1, 1, 32'h80, 32'h1111, 5'h4);
        step();
        set_ld(1, 1, 32'h44, 6'h4, 3'h2, 5'h3);
        step();
        set_st(1, 1, 1, 32'h88, 32'h2222, 5'h5);
        step();
        chk("rr_third_is_load", ld_srv_address, 32'h44);

        // Lone fetched load at 0x100.
        set_st(0, 1, 0, 32'h0, 32'h0, 5'h0);
        set_ld(1, 1, 32'h100, 6'h2A, 3'h5, 5'h11);
        step();
        chk("lone_load_addr", ld_srv_address, 32'h100);
        chk("lone_load_dest", {ld_srv_dest, ld_srv_ticket}, {6'h2A, 3'h5});

        // Refill of 0x204 with a stalled request and a slow response.
        set_ld(1, 0, 32'h204, 6'h1, 3'h0, 5'h1);
        step();
        chk("miss_aligned", mem_req_address, 32'h200);
        repeat (3) step();
        mem_req_ready = 1;
        step();
        mem_req_ready = 0;
        repeat (4) step();
        mem_resp_valid = 1;
        step();
        mem_resp_valid = 0;
        chk("fill_pulse", {update_valid, update_address}, {1'b1, 32'h200});
        step();
        step();
        chk("no_second_req", mem_req_valid, 1'b0);
        set_ld(1, 1, 32'h204, 6'h1, 3'h0, 5'h1);
        step();

        // Same-word store blocks the load until it pops.
        set_ld(1, 1, 32'h300, 6'h7, 3'h3, 5'h6);
        set_st(1, 1, 1, 32'h300, 32'hDEADBEEF, 5'h9);
        step();
        chk("st_first_data", cache_wr_data, 32'hDEADBEEF);
        set_st(0, 1, 0, 32'h0, 32'h0, 5'h0);
        step();
        chk("load_after_store", ld_srv_address, 32'h300);

        // Full store buffer overrides the round-robin that favours the store anyway; repeat after a store win.
        set_ld(1, 1, 32'h400, 6'h8, 3'h4, 5'h7);
        set_st(1, 0, 1, 32'h500, 32'h5555, 5'hA);
        step();
        step();
        chk("full_store_wins", cache_wr_en, 1'b1);

        // Asynchronous reset while waiting on memory.
        set_st(0, 1, 0, 32'h0, 32'h0, 5'h0);
        set_ld(1, 0, 32'h620, 6'h1, 3'h1, 5'h1);
        step();
        mem_req_ready = 1;
        step();
        mem_req_ready = 0;
        step();
        chk("in_wait", busy, 1'b1);
        set_ld(1, 1, 32'h700, 6'h1, 3'h1, 5'h1);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_rst");
        model_reset();
        @(negedge clk);
        mem_resp_valid = 1;
        @(negedge clk);
        rst_n = 1'b1;
        set_ld(0, 0, 32'h0, 6'h0, 3'h0, 5'h0);
        step();
        mem_resp_valid = 0;

        // Random traffic over a few blocks so same-word conflicts and misses are frequent.
        for (int i = 0; i < 600; i++) begin
            set_ld($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                   32'h1000 + 32'($urandom_range(0, 3) * 32 + $urandom_range(0, 3) * 4),
                   6'($urandom), 3'($urandom), 5'($urandom));
            set_st($urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                   32'h1000 + 32'($urandom_range(0, 3) * 32 + $urandom_range(0, 3) * 4),
                   $urandom, 5'($urandom));
            mem_req_ready = $urandom_range(0, 1) == 1;
            mem_resp_valid = $urandom_range(0, 3) == 0;
            step();
        end
`ifdef LDST_SCHED_PERF_EN
        chk("perf_refills", perf_refills, 32'(m_refills));
        chk("perf_ld_blocked", perf_ld_blocked, 32'(m_blocked));
        chk("perf_st_full", perf_st_full, 32'(m_full));
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ldst_drain_sched.md
Name: ldst_drain_sched

Overview:
- Scheduler sitting between the data cache's load buffer and store buffer (both ld_st_buffer instances) and the shared cache data-array port and main-memory refill port.
- Each cycle, arbitrates which buffer head (if already fetched) is drained and popped.
- Sequences single-outstanding block refills for heads that are not yet fetched.
- Broadcasts refill completion back to both buffers through their update ports.

Parameters:
- ADDR_BITS, 32, address width
- DATA_WIDTH, 32, store data width
- BLOCK_ID_START, 5, LSB of block ID; refill addresses are aligned by zeroing bits [BLOCK_ID_START-1:0]
- R_WIDTH, 6, destination register width
- MICROOP, 5, micro-op width
- ROB_TICKET, 3, ROB ticket width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ld_valid  in  1  load buffer non-empty
- ld_head_isfetched  in  1  load head block present in cache
- ld_head_address  in  ADDR_BITS  load head address
- ld_head_microop  in  MICROOP  load head micro-op
- ld_head_dest  in  R_WIDTH  load head destination
- ld_head_ticket  in  ROB_TICKET  load head ticket
- ld_pop  out  1  pop load buffer
- st_valid  in  1  store buffer non-empty
- st_ready  in  1  store buffer not full
- st_head_isfetched  in  1  store head block present
- st_head_address  in  ADDR_BITS  store head address
- st_head_data  in  DATA_WIDTH  store head data
- st_head_microop  in  MICROOP  store head micro-op
- st_pop  out  1  pop store buffer
- mem_req_valid  out  1  refill request
- mem_req_ready  in  1  memory accepts request
- mem_req_address  out  ADDR_BITS  block-aligned refill address
- mem_resp_valid  in  1  refill data written to cache (single-cycle pulse)
- update_valid  out  1  to both buffers' valid_update
- update_address  out  ADDR_BITS  to both buffers' update_address
- cache_wr_en  out  1  store commit to cache array
- cache_wr_address  out  ADDR_BITS
- cache_wr_data  out  DATA_WIDTH
- cache_wr_microop  out  MICROOP
- ld_srv_valid  out  1  load served, cache read issued
- ld_srv_address  out  ADDR_BITS
- ld_srv_dest  out  R_WIDTH
- ld_srv_ticket  out  ROB_TICKET
- ld_srv_microop  out  MICROOP
- busy  out  1  refill FSM not IDLE

Behaviour:
- Reset: FSM=IDLE, last_grant=store (load wins first tie). All outputs are 0: mem_req_valid, update_valid, cache_wr_en, ld_srv_valid, pops, busy, and all address/data fields.
- Reset mid-refill aborts immediately. A late mem_resp_valid while IDLE is ignored.
- Candidates:
  - ld_ok = ld_valid & ld_head_isfetched & !(st_valid & st_head_address[ADDR_BITS-1:2]==ld_head_address[ADDR_BITS-1:2]). A load never passes an older same-word store.
  - st_ok = st_valid & st_head_isfetched.
- Grant, at most one per cycle:
  - If !st_ready & st_ok, store wins.
  - Else if only one candidate is ok, it wins.
  - Else both ok: round-robin, opposite of last_grant. last_grant updates only on an actual grant.
- Grant effect:
  - ld_pop/st_pop are combinational, asserted in the grant cycle.
  - cache_wr_* and ld_srv_* are registered, valid exactly 1 cycle after the grant (latency 1), otherwise valid=0 with fields holding their last value.
  - No grant during a FILL cycle (the array is owned by refill).
- Refill FSM:
  - IDLE -> REQ when there is a miss candidate: ld_valid & !ld_head_isfetched (preferred), else st_valid & !st_head_isfetched. A store miss is preferred when !st_ready. On this transition, latch the aligned address into mem_req_address.
  - REQ: mem_req_valid=1 with address held stable until mem_req_ready. Request and ready in the same cycle -> WAIT.
  - WAIT: hold until mem_resp_valid -> FILL.
  - FILL: one cycle; update_valid=1, update_address=latched address -> IDLE.
  - An IDLE->REQ transition is not allowed in the cycle after FILL. Heads see isfetched only then, which avoids a duplicate refill.
- busy=1 in REQ, WAIT and FILL.
- Both buffers empty: no pops, no requests.
- Simultaneous grant and FSM transition is allowed, except during FILL as stated.

Optional Feature:
- Macro LDST_SCHED_PERF_EN.
- When defined: adds outputs perf_refills [31:0] (increments on each REQ->WAIT), perf_ld_blocked [31:0] (increments each cycle a fetched load is blocked by the same-word store rule or lost arbitration) and perf_st_full [31:0] (increments each cycle !st_ready).
  - All counters saturate at 0xFFFFFFFF and reset to 0.
- When undefined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Only a load head, fetched, addr 0x100 -> ld_pop the same cycle; next cycle ld_srv_valid=1, ld_srv_address=0x100, dest/ticket echoed.
- Load and store heads both fetched, different words, three consecutive cycles, buffers refilled -> grants alternate ld,st,ld; exactly one pop per cycle.
- Load head 0x204 not fetched -> mem_req_valid, address 0x200. Hold mem_req_ready=0 for 3 cycles: address stable. Then ready, then mem_resp_valid after 5 cycles -> one-cycle update_valid with 0x200, busy drops the next cycle, no second request.
- Store head 0x300 data 0xDEADBEEF fetched, load head 0x300 fetched -> store granted; next cycle cache_wr_en=1 with that data; load is granted only after the store pops.
- st_ready=0 with load and store both ok and last_grant=load -> store wins. Assert rst_n low during WAIT -> all outputs 0 and FSM IDLE asynchronously.
